// File: rtl/hist_equalize_lut.sv
// Histogram-equalization LUT builder: walks the histogram bins, accumulates the CDF
// and writes floor(cdf*(2^OUT_W-1)/total) per bin. Optional macro HIST_CDF_MIN_EN.
module hist_equalize_lut #(
  parameter int BIN_W = 6,
  parameter int CNT_W = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [8:0]       dim,
  input  logic [BIN_W-1:0] hist_bins,
  output logic [BIN_W-1:0] hist_rd_addr,
  input  logic [CNT_W-1:0] hist_rd_data,
  output logic             lut_we,
  output logic [BIN_W-1:0] lut_addr,
  output logic [OUT_W-1:0] lut_data,
  output logic             busy,
  output logic             done
);

  localparam int TOT_W     = 18;
  localparam int NUM_W     = 32;
  localparam int DIV_STEPS = 32;
  localparam logic [OUT_W-1:0] MAX_LEVEL = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_ACC,
    S_DIV,
    S_WR,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [TOT_W-1:0] total_q;
  logic [BIN_W-1:0] bin_q;
  logic [BIN_W-1:0] last_bin_q;
  logic [CNT_W-1:0] cdf_q;
  logic [CNT_W-1:0] cdf_new;

  logic [NUM_W-1:0] num_q;
  logic [TOT_W-1:0] den_q;
  logic [TOT_W-1:0] rem_q;
  logic [4:0]       step_q;
  logic             force_zero_q;
  logic             force_max_q;

  logic [NUM_W-1:0] ld_num;
  logic [TOT_W-1:0] ld_den;
  logic             ld_zero;
  logic             ld_max;

  logic [TOT_W:0]   rem_sh;
  logic             rem_ge;
  logic [TOT_W-1:0] rem_nx;
  logic [NUM_W-1:0] num_nx;
  logic [OUT_W-1:0] level_nx;

`ifdef HIST_CDF_MIN_EN
  logic [CNT_W-1:0] cdf_min_q;
  logic             cdf_min_vld_q;
  logic [CNT_W-1:0] eff_min;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RD;
      S_RD:   state_d = S_ACC;
      S_ACC:  state_d = S_DIV;
      S_DIV:  if (step_q == 5'(DIV_STEPS - 1)) state_d = S_WR;
      S_WR:   state_d = (bin_q == last_bin_q) ? S_DONE : S_RD;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Divider operands are formed from the freshly accumulated CDF; the clamp and
  // zero cases are decided here so the division itself never needs more bits.
  always_comb begin
    cdf_new = cdf_q + hist_rd_data;
`ifdef HIST_CDF_MIN_EN
    eff_min = cdf_min_vld_q ? cdf_min_q : cdf_new;
    ld_zero = (cdf_new == '0) || (total_q == '0) || (CNT_W'(total_q) == eff_min);
    ld_max  = (cdf_new >= CNT_W'(total_q));
    ld_den  = total_q - eff_min[TOT_W-1:0];
    ld_num  = NUM_W'(cdf_new[TOT_W-1:0] - eff_min[TOT_W-1:0]) * NUM_W'(MAX_LEVEL);
`else
    ld_zero = (total_q == '0);
    ld_max  = (cdf_new >= CNT_W'(total_q));
    ld_den  = total_q;
    ld_num  = NUM_W'(cdf_new[TOT_W-1:0]) * NUM_W'(MAX_LEVEL);
`endif
  end

  always_comb begin
    rem_sh   = {rem_q, num_q[NUM_W-1]};
    rem_ge   = (rem_sh >= {1'b0, den_q});
    rem_nx   = rem_ge ? (rem_sh[TOT_W-1:0] - den_q) : rem_sh[TOT_W-1:0];
    num_nx   = {num_q[NUM_W-2:0], rem_ge};
    level_nx = force_zero_q ? '0 : (force_max_q ? MAX_LEVEL : num_nx[OUT_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      total_q      <= '0;
      bin_q        <= '0;
      last_bin_q   <= '0;
      cdf_q        <= '0;
      num_q        <= '0;
      den_q        <= '0;
      rem_q        <= '0;
      step_q       <= '0;
      force_zero_q <= 1'b0;
      force_max_q  <= 1'b0;
      hist_rd_addr <= '0;
      lut_we       <= 1'b0;
      lut_addr     <= '0;
      lut_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef HIST_CDF_MIN_EN
      cdf_min_q     <= '0;
      cdf_min_vld_q <= 1'b0;
`endif
    end else begin
      lut_we <= 1'b0;
      done   <= 1'b0;
      busy   <= (state_d != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            total_q      <= {9'd0, dim} * {9'd0, dim};
            last_bin_q   <= hist_bins;
            bin_q        <= '0;
            cdf_q        <= '0;
            hist_rd_addr <= '0;
`ifdef HIST_CDF_MIN_EN
            cdf_min_q     <= '0;
            cdf_min_vld_q <= 1'b0;
`endif
          end
        end
        S_ACC: begin
          cdf_q        <= cdf_new;
          num_q        <= ld_num;
          den_q        <= ld_den;
          rem_q        <= '0;
          step_q       <= '0;
          force_zero_q <= ld_zero;
          force_max_q  <= ld_max;
`ifdef HIST_CDF_MIN_EN
          if (!cdf_min_vld_q && (cdf_new != '0)) begin
            cdf_min_q     <= cdf_new;
            cdf_min_vld_q <= 1'b1;
          end
`endif
        end
        S_DIV: begin
          num_q  <= num_nx;
          rem_q  <= rem_nx;
          step_q <= step_q + 5'd1;
          if (step_q == 5'(DIV_STEPS - 1)) begin
            lut_we   <= 1'b1;
            lut_addr <= bin_q;
            lut_data <= level_nx;
          end
        end
        S_WR: begin
          // Comparing before incrementing lets the last bin (all ones) finish without wrap.
          if (bin_q == last_bin_q) begin
            done <= 1'b1;
          end else begin
            bin_q        <= bin_q + 1'b1;
            hist_rd_addr <= bin_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
